// File: rtl/lcd_pkg.sv
// Shared types, command bit positions and DDRAM address helpers for the
// HD44780-style LCD bus responder.
package lcd_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR, BUSY} lcd_state_e;

    localparam int CMD_SET_DDRAM = 7;
    localparam int CMD_SET_CGRAM = 6;
    localparam int CMD_FUNC_SET  = 5;
    localparam int CMD_SHIFT     = 4;
    localparam int CMD_DISP_CTRL = 3;
    localparam int CMD_ENTRY     = 2;
    localparam int CMD_HOME      = 1;
    localparam int CMD_CLEAR     = 0;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam int         LINE_LEN   = 16;
    localparam logic [6:0] AC_WRAP0   = 7'h27;
    localparam logic [6:0] AC_WRAP1   = 7'h67;
    localparam logic [7:0] BLANK      = 8'h20;

    // Bases are 16-aligned, so the cell index within a line is ac[3:0].
    function automatic logic on_line(input logic [6:0] ac, input logic [6:0] base);
        logic [6:0] off;
        off = ac - base;
        return off < 7'(LINE_LEN);
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (ac == AC_WRAP0)      nxt = LINE1_BASE;
            else if (ac == AC_WRAP1) nxt = LINE0_BASE;
            else                     nxt = ac + 7'd1;
        end else begin
            if (ac == LINE1_BASE)      nxt = AC_WRAP0;
            else if (ac == LINE0_BASE) nxt = AC_WRAP1;
            else                       nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_in_sync.sv
// Two-flop synchronizer for the LCD bus signals, all with matched delay,
// plus EN rise/fall pulses taken from the synchronized EN.
module lcd_in_sync (
    input  logic       I_CLK,
    input  logic       I_RSTF,
    input  logic       I_EN,
    input  logic       I_RS,
    input  logic       I_RWF,
    input  logic [7:0] I_DATA,
    output logic       O_EN,
    output logic       O_RS,
    output logic       O_RWF,
    output logic [7:0] O_DATA,
    output logic       O_RISE,
    output logic       O_FALL
);
    // {EN, RWF, RS, DATA}; EN and RWF reset high so reset release is edge-free.
    localparam logic [10:0] SYNC_RST = {1'b1, 1'b1, 1'b0, 8'h00};

    logic [10:0] s1_q, s1_d, s2_q, s2_d;
    logic        en_dly_q, en_dly_d;

    always_comb begin
        s1_d     = {I_EN, I_RWF, I_RS, I_DATA};
        s2_d     = s1_q;
        en_dly_d = s2_q[10];
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            s1_q     <= SYNC_RST;
            s2_q     <= SYNC_RST;
            en_dly_q <= 1'b1;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            en_dly_q <= en_dly_d;
        end
    end

    assign O_EN   = s2_q[10];
    assign O_RWF  = s2_q[9];
    assign O_RS   = s2_q[8];
    assign O_DATA = s2_q[7:0];
    assign O_RISE = s2_q[10] & ~en_dly_q;
    assign O_FALL = ~s2_q[10] & en_dly_q;

endmodule

// File: rtl/lcd_bus_rsp.sv
// HD44780-style responder: decodes LCD bus commands into display flags,
// holds a 2x16 DDRAM image and answers busy-flag and data reads.
module lcd_bus_rsp
    import lcd_pkg::*;
#(
    parameter int BUSY_CYC = 1000,
    parameter int CLR_CYC  = 1000
) (
    input  logic             I_CLK,
    input  logic             I_RSTF,
    input  logic             I_LCD_EN,
    input  logic             I_LCD_RS,
    input  logic             I_LCD_RWF,
    input  logic [7:0]       I_LCD_DATA,
    output logic [7:0]       O_LCD_DATA,
    output logic             O_LCD_DATA_OE,
    output logic [0:15][7:0] O_LINE0,
    output logic [0:15][7:0] O_LINE1,
    output logic             O_DISP_ON,
    output logic             O_CURSOR_ON,
    output logic             O_BLINK_ON,
    output logic             O_FSET_OK,
    output logic             O_BUSY,
    output logic             O_CMD_STB,
    output logic             O_WR_STB,
    output logic             O_ERR,
    output lcd_state_e       O_DBG_STATE
);
    // Bus handshake: a write is taken on a synchronized EN fall only in IDLE,
    // otherwise dropped with O_ERR; reads drive data while synchronized EN is high.
    logic       en_s, rs_s, rwf_s, en_fall, unused_rise;
    logic [7:0] data_s;

    lcd_in_sync u_sync (
        .I_CLK  (I_CLK),
        .I_RSTF (I_RSTF),
        .I_EN   (I_LCD_EN),
        .I_RS   (I_LCD_RS),
        .I_RWF  (I_LCD_RWF),
        .I_DATA (I_LCD_DATA),
        .O_EN   (en_s),
        .O_RS   (rs_s),
        .O_RWF  (rwf_s),
        .O_DATA (data_s),
        .O_RISE (unused_rise),
        .O_FALL (en_fall)
    );

    lcd_state_e       state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [4:0]       idx_q, idx_d;
    logic [6:0]       ac_q, ac_d;
    logic             id_q, id_d;
    logic [2:0]       dcb_q, dcb_d;
    logic             fset_q, fset_d;
    logic [0:15][7:0] line0_q, line0_d, line1_q, line1_d;
    logic             cmd_rs_q, cmd_rs_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             cmd_stb_q, cmd_stb_d, wr_stb_q, wr_stb_d, err_q, err_d;
    logic [7:0]       rd_data_q, rd_data_d, rd_cell;
    logic             rd_oe_q, rd_oe_d, busy;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        ac_d      = ac_q;
        id_d      = id_q;
        dcb_d     = dcb_q;
        fset_d    = fset_q;
        line0_d   = line0_q;
        line1_d   = line1_q;
        cmd_rs_d  = cmd_rs_q;
        cmd_d     = cmd_q;
        cmd_stb_d = 1'b0;
        wr_stb_d  = 1'b0;
        err_d     = 1'b0;
        busy      = (state_q != IDLE);

        rd_cell = BLANK;
        if (on_line(ac_q, LINE0_BASE))      rd_cell = line0_q[ac_q[3:0]];
        else if (on_line(ac_q, LINE1_BASE)) rd_cell = line1_q[ac_q[3:0]];
        rd_oe_d   = en_s & rwf_s;
        rd_data_d = rd_oe_d ? (rs_s ? rd_cell : {busy, ac_q}) : 8'h00;

        if (en_fall) begin
            if (!rwf_s) begin
                if (state_q == IDLE) begin
                    cmd_rs_d = rs_s;
                    cmd_d    = data_s;
                    state_d  = EXEC;
                end else begin
                    err_d = 1'b1;
                end
            end else if (rs_s) begin
                if (state_q == IDLE) ac_d  = ac_step(ac_q, id_q);
                else                 err_d = 1'b1;
            end
        end

        case (state_q)
            EXEC: begin
                state_d = BUSY;
                cnt_d   = 32'(BUSY_CYC - 1);
                if (cmd_rs_q) begin
                    wr_stb_d = 1'b1;
                    if (on_line(ac_q, LINE0_BASE))      line0_d[ac_q[3:0]] = cmd_q;
                    else if (on_line(ac_q, LINE1_BASE)) line1_d[ac_q[3:0]] = cmd_q;
                    ac_d = ac_step(ac_q, id_q);
                end else begin
                    cmd_stb_d = 1'b1;
                    if (cmd_q[CMD_SET_DDRAM]) begin
                        ac_d = cmd_q[6:0];
                    end else if (cmd_q[CMD_SET_CGRAM]) begin
                        ac_d = ac_q;
                    end else if (cmd_q[CMD_FUNC_SET]) begin
                        fset_d = (cmd_q[4:3] == 2'b11);
                    end else if (cmd_q[CMD_SHIFT]) begin
                        if (!cmd_q[3]) ac_d = ac_step(ac_q, cmd_q[2]);
                    end else if (cmd_q[CMD_DISP_CTRL]) begin
                        dcb_d = cmd_q[2:0];
                    end else if (cmd_q[CMD_ENTRY]) begin
                        id_d = cmd_q[1];
                    end else if (cmd_q[CMD_HOME]) begin
                        ac_d  = 7'h00;
                        cnt_d = 32'(CLR_CYC - 1);
                    end else if (cmd_q[CMD_CLEAR]) begin
                        ac_d    = 7'h00;
                        id_d    = 1'b1;
                        idx_d   = 5'd0;
                        state_d = CLEAR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CLEAR: begin
                if (idx_q[4]) line1_d[idx_q[3:0]] = BLANK;
                else          line0_d[idx_q[3:0]] = BLANK;
                if (idx_q == 5'd31) begin
                    state_d = BUSY;
                    cnt_d   = 32'(CLR_CYC - 1);
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            BUSY: begin
                if (cnt_q == 32'd0) state_d = IDLE;
                else                cnt_d   = cnt_q - 32'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            idx_q     <= 5'd0;
            ac_q      <= 7'h00;
            id_q      <= 1'b1;
            dcb_q     <= 3'b000;
            fset_q    <= 1'b0;
            line0_q   <= {16{BLANK}};
            line1_q   <= {16{BLANK}};
            cmd_rs_q  <= 1'b0;
            cmd_q     <= 8'h00;
            cmd_stb_q <= 1'b0;
            wr_stb_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= 8'h00;
            rd_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            ac_q      <= ac_d;
            id_q      <= id_d;
            dcb_q     <= dcb_d;
            fset_q    <= fset_d;
            line0_q   <= line0_d;
            line1_q   <= line1_d;
            cmd_rs_q  <= cmd_rs_d;
            cmd_q     <= cmd_d;
            cmd_stb_q <= cmd_stb_d;
            wr_stb_q  <= wr_stb_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            rd_oe_q   <= rd_oe_d;
        end
    end

    assign O_LCD_DATA    = rd_data_q;
    assign O_LCD_DATA_OE = rd_oe_q;
    assign O_LINE0       = line0_q;
    assign O_LINE1       = line1_q;
    assign O_DISP_ON     = dcb_q[2];
    assign O_CURSOR_ON   = dcb_q[1];
    assign O_BLINK_ON    = dcb_q[0];
    assign O_FSET_OK     = fset_q;
    assign O_BUSY        = busy;
    assign O_CMD_STB     = cmd_stb_q;
    assign O_WR_STB      = wr_stb_q;
    assign O_ERR         = err_q;
    assign O_DBG_STATE   = state_q;

endmodule

// File: tb/tb_lcd_bus_rsp.sv
// Self-checking bench for lcd_bus_rsp: bus driver tasks, a strobe
// scoreboard, a table of AC/DDRAM vectors and multi-cycle corner sequences.
module tb_lcd_bus_rsp;
    import lcd_pkg::*;

    localparam logic [2:0] K_WR  = 3'b100;
    localparam logic [2:0] K_CMD = 3'b010;
    localparam logic [2:0] K_ERR = 3'b001;

    logic             clk = 1'b0;
    logic             rstf;
    logic             lcd_en, lcd_rs, lcd_rwf;
    logic [7:0]       lcd_data;
    logic [7:0]       o_lcd_data;
    logic             o_oe;
    logic [0:15][7:0] o_line0, o_line1;
    logic             o_disp, o_cur, o_blink, o_fset, o_busy;
    logic             o_cmd_stb, o_wr_stb, o_err;
    lcd_state_e       dbg_state;

    int         n_cmp = 0;
    int         n_err = 0;
    int         stb_cnt = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        logic [6:0] ac0;
        logic       inc;
        logic [7:0] wd;
        logic [6:0] exp_ac;
        int         exp_cell;
    } vec_t;

    vec_t             vecs[6];
    logic [0:15][7:0] exp_l0, exp_l1;

    always #5 clk = ~clk;

    lcd_bus_rsp dut (
        .I_CLK         (clk),
        .I_RSTF        (rstf),
        .I_LCD_EN      (lcd_en),
        .I_LCD_RS      (lcd_rs),
        .I_LCD_RWF     (lcd_rwf),
        .I_LCD_DATA    (lcd_data),
        .O_LCD_DATA    (o_lcd_data),
        .O_LCD_DATA_OE (o_oe),
        .O_LINE0       (o_line0),
        .O_LINE1       (o_line1),
        .O_DISP_ON     (o_disp),
        .O_CURSOR_ON   (o_cur),
        .O_BLINK_ON    (o_blink),
        .O_FSET_OK     (o_fset),
        .O_BUSY        (o_busy),
        .O_CMD_STB     (o_cmd_stb),
        .O_WR_STB      (o_wr_stb),
        .O_ERR         (o_err),
        .O_DBG_STATE   (dbg_state)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe/error pulse must match the head of exp_q.
    always @(negedge clk) begin : monitor
        logic [2:0] kind;
        if (rstf && (o_cmd_stb || o_wr_stb || o_err)) begin
            kind = {o_wr_stb, o_cmd_stb, o_err};
            if (o_cmd_stb || o_wr_stb) stb_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL strobe: got %b, none expected", kind);
            end else begin
                check("strobe", 128'(kind), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic bus_write(input logic rs, input logic [7:0] d, input logic [2:0] kind);
        @(negedge clk);
        lcd_rs   = rs;
        lcd_rwf  = 1'b0;
        lcd_data = d;
        exp_q.push_back(kind);
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
        repeat (3) @(negedge clk);
        lcd_rs  = 1'b0;
        lcd_rwf = 1'b1;
        @(negedge clk);
        lcd_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe);
        @(negedge clk);
        lcd_rs  = rs;
        lcd_rwf = 1'b1;
        repeat (5) @(negedge clk);
        d  = o_lcd_data;
        oe = o_oe;
        lcd_en = 1'b0;
        repeat (3) @(negedge clk);
        lcd_rs = 1'b0;
        @(negedge clk);
        lcd_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((o_busy || dbg_state != IDLE) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_status(input string name, input logic busy, input logic [6:0] ac);
        repeat (4) @(negedge clk);
        check({name, "_oe"}, 128'(o_oe), 128'(1'b1));
        check(name, 128'(o_lcd_data), 128'({busy, ac}));
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_line0"}, o_line0, {16{8'h20}});
        check({name, "_line1"}, o_line1, {16{8'h20}});
        check({name, "_outs"},
              128'({o_lcd_data, o_oe, o_disp, o_cur, o_blink, o_fset, o_busy,
                    o_cmd_stb, o_wr_stb, o_err}), 128'(0));
        check({name, "_state"}, 128'(dbg_state), 128'(IDLE));
    endtask

    task automatic write_idle(input logic rs, input logic [7:0] d, input logic [2:0] kind);
        bus_write(rs, d, kind);
        wait_idle();
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] rd;
        logic       rd_oe;
        logic       cur_id;
        int         n, cnt, stb0;
        string      s0, s1;
        logic [7:0] init_seq[7];

        s0 = "HELLO WORLD 0123";
        s1 = "abcdefghijklmnop";
        init_seq = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0F, 8'h01, 8'h06};
        vecs[0] = '{7'h00, 1'b1, 8'h41, 7'h01, 0};
        vecs[1] = '{7'h27, 1'b1, 8'h43, 7'h40, -1};
        vecs[2] = '{7'h67, 1'b1, 8'h44, 7'h00, -1};
        vecs[3] = '{7'h4F, 1'b1, 8'h47, 7'h50, 31};
        vecs[4] = '{7'h00, 1'b0, 8'h45, 7'h67, 0};
        vecs[5] = '{7'h40, 1'b0, 8'h46, 7'h27, 16};

        lcd_en   = 1'b1;
        lcd_rwf  = 1'b1;
        lcd_rs   = 1'b0;
        lcd_data = 8'h00;
        rstf     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rstf = 1'b1;
        check_status("status_after_reset", 1'b0, 7'h00);

        // Power-on init sequence.
        foreach (init_seq[i]) write_idle(1'b0, init_seq[i], K_CMD);
        check("init_fset", 128'(o_fset), 128'(1'b1));
        check("init_dcb", 128'({o_disp, o_cur, o_blink}), 128'(3'b111));
        check("init_line0", o_line0, {16{8'h20}});
        check("init_line1", o_line1, {16{8'h20}});
        check_status("init_ac", 1'b0, 7'h00);

        // Two full lines of text.
        stb0 = stb_cnt;
        write_idle(1'b0, 8'h80, K_CMD);
        for (int i = 0; i < 16; i++) begin
            write_idle(1'b1, s0[i], K_WR);
            exp_l0[i] = s0[i];
        end
        write_idle(1'b0, 8'hC0, K_CMD);
        for (int i = 0; i < 16; i++) begin
            write_idle(1'b1, s1[i], K_WR);
            exp_l1[i] = s1[i];
        end
        check("text_line0", o_line0, exp_l0);
        check("text_line1", o_line1, exp_l1);
        check("text_stb_count", 128'(stb_cnt - stb0), 128'(34));
        check_status("text_ac", 1'b0, 7'h50);

        // Data reads: in-window cell, out-of-window blank, AC steps.
        write_idle(1'b0, 8'h80, K_CMD);
        bus_read(1'b1, rd, rd_oe);
        check("read_cell_oe", 128'(rd_oe), 128'(1'b1));
        check("read_cell", 128'(rd), 128'(8'h48));
        check_status("read_cell_ac", 1'b0, 7'h01);
        write_idle(1'b0, 8'hA0, K_CMD);
        bus_read(1'b1, rd, rd_oe);
        check("read_blank", 128'(rd), 128'(8'h20));
        check_status("read_blank_ac", 1'b0, 7'h21);

        // Table: AC set, optional entry mode, one data write.
        cur_id = 1'b1;
        foreach (vecs[v]) begin
            if (vecs[v].inc != cur_id) begin
                write_idle(1'b0, vecs[v].inc ? 8'h06 : 8'h04, K_CMD);
                cur_id = vecs[v].inc;
            end
            write_idle(1'b0, {1'b1, vecs[v].ac0}, K_CMD);
            write_idle(1'b1, vecs[v].wd, K_WR);
            if (vecs[v].exp_cell >= 16)     exp_l1[vecs[v].exp_cell - 16] = vecs[v].wd;
            else if (vecs[v].exp_cell >= 0) exp_l0[vecs[v].exp_cell] = vecs[v].wd;
            check_status($sformatf("vec%0d_ac", v), 1'b0, vecs[v].exp_ac);
            check($sformatf("vec%0d_line0", v), o_line0, exp_l0);
            check($sformatf("vec%0d_line1", v), o_line1, exp_l1);
        end
        write_idle(1'b0, 8'h06, K_CMD);

        // Write and data read while busy are both dropped with O_ERR.
        write_idle(1'b0, 8'h80, K_CMD);
        bus_write(1'b1, 8'h58, K_WR);
        repeat (2) @(negedge clk);
        bus_write(1'b1, 8'h59, K_ERR);
        exp_q.push_back(K_ERR);
        bus_read(1'b1, rd, rd_oe);
        check_status("busy_status", 1'b1, 7'h01);
        wait_idle();
        exp_l0[0] = 8'h58;
        check("busy_drop_line0", o_line0, exp_l0);
        check_status("busy_drop_ac", 1'b0, 7'h01);

        // Cursor shift, display control, function set.
        write_idle(1'b0, 8'hA7, K_CMD);
        write_idle(1'b0, 8'h14, K_CMD);
        check_status("shift_right", 1'b0, 7'h40);
        write_idle(1'b0, 8'h10, K_CMD);
        check_status("shift_left", 1'b0, 7'h27);
        write_idle(1'b0, 8'h0D, K_CMD);
        check("disp_ctrl", 128'({o_disp, o_cur, o_blink}), 128'(3'b101));
        write_idle(1'b0, 8'h30, K_CMD);
        check("fset_1line", 128'(o_fset), 128'(1'b0));
        write_idle(1'b0, 8'h38, K_CMD);
        check("fset_2line", 128'(o_fset), 128'(1'b1));

        // Clear: busy for 1+32+CLR_CYC cycles, blanks lines, restores ID=1.
        write_idle(1'b0, 8'h04, K_CMD);
        n   = 0;
        cnt = 0;
        fork
            bus_write(1'b0, 8'h01, K_CMD);
            begin
                while (!o_busy && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                while (o_busy && cnt < 5000) begin
                    cnt++;
                    @(negedge clk);
                end
            end
        join
        check("clear_busy_cycles", 128'(cnt), 128'(1033));
        wait_idle();
        check("clear_line0", o_line0, {16{8'h20}});
        check("clear_line1", o_line1, {16{8'h20}});
        check_status("clear_ac", 1'b0, 7'h00);
        write_idle(1'b1, 8'h5A, K_WR);
        check_status("clear_id_inc", 1'b0, 7'h01);

        // Reset in the middle of a clear walk.
        write_idle(1'b0, 8'hC0, K_CMD);
        write_idle(1'b1, 8'h51, K_WR);
        check("pre_reset_line1", 128'(o_line1[0]), 128'(8'h51));
        bus_write(1'b0, 8'h01, K_CMD);
        n = 0;
        while (dbg_state != CLEAR && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_clear", 128'(dbg_state), 128'(CLEAR));
        repeat (3) @(negedge clk);
        rstf = 1'b0;
        #1;
        check_reset_vals("mid_clear_reset");
        repeat (3) @(negedge clk);
        rstf = 1'b1;
        repeat (10) @(negedge clk);
        check("post_release_state", 128'(dbg_state), 128'(IDLE));
        check("post_release_busy", 128'(o_busy), 128'(1'b0));
        check_status("post_release_ac", 1'b0, 7'h00);
        check("pending_strobes", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_bus_rsp.md
# lcd_bus_rsp

Synthesizable HD44780-style character-LCD responder for the 8-bit LCD bus (EN/RS/RWF/DATA). It sits on the far end of the LCD bus initiator and decodes commands into display-control flags. It also holds a 2×16 DDRAM image, answers busy-flag and data reads, and exposes the two visible lines as parallel outputs. It serves as an on-chip loopback target for bring-up and as the bus model in system benches.

## Interface
- BUSY_CYC, 1000: busy time in I_CLK cycles after any accepted command or data write (except clear/home).
- CLR_CYC, 1000: busy time in I_CLK cycles after clear display or return home, counted after the clear walk.
- I_CLK  in  1  system clock.
- I_RSTF  in  1  asynchronous, active-low reset.
- I_LCD_EN  in  1  bus enable. Idles high. Writes are latched on its falling edge.
- I_LCD_RS  in  1  0 = command/status, 1 = data.
- I_LCD_RWF  in  1  0 = write, 1 = read.
- I_LCD_DATA  in  8  write data from the initiator.
- O_LCD_DATA  out  8  read data.
- O_LCD_DATA_OE  out  1  read-data drive enable.
- O_LINE0  out  [0:15][7:0]  DDRAM 0x00–0x0F.
- O_LINE1  out  [0:15][7:0]  DDRAM 0x40–0x4F.
- O_DISP_ON / O_CURSOR_ON / O_BLINK_ON  out  1 each  display-control bits D/C/B.
- O_FSET_OK  out  1  last function set was 8-bit, 2-line (0x38 or 0x3C).
- O_BUSY  out  1  busy flag.
- O_CMD_STB  out  1  one-cycle pulse per accepted command write.
- O_WR_STB  out  1  one-cycle pulse per accepted data write.
- O_ERR  out  1  one-cycle pulse when a write arrives while busy; that write is dropped.

## Operation
- Input conditioning:
  - EN, RS, RWF and DATA pass through an identical 2-flop synchronizer, so all four have matched delay.
  - Synchronizer flops reset to EN=1 and RWF=1, so reset release produces no edge.
  - The initiator must hold RS/RWF/DATA stable for ≥2 cycles after EN falls.
- Write (RWF=0) is accepted on a synchronized EN fall only in state IDLE. Otherwise the write is dropped and O_ERR pulses.
- Command decode (RS=0), highest set bit wins:
  - b7: AC ← DATA[6:0].
  - b6: CGRAM address; ignored, but starts busy.
  - b5: function set; O_FSET_OK ← (DATA[4:3]==2'b11).
  - b4: cursor/display shift. S/C=0 moves AC by R/L. S/C=1 is ignored.
  - b3: display control; D/C/B ← DATA[2:0].
  - b2: entry mode; ID ← DATA[1]. The S bit is ignored.
  - b1: return home; AC ← 0.
  - b0: clear; all DDRAM ← 0x20, AC ← 0, ID ← 1.
  - 0x00: no-op; no busy.
- Data write (RS=1): DDRAM[AC] ← DATA if AC is in 0x00–0x0F or 0x40–0x4F; otherwise the byte is discarded. AC then steps.
- AC step, 7-bit:
  - Increment: 0x27 → 0x40, 0x67 → 0x00.
  - Decrement: 0x40 → 0x27, 0x00 → 0x67.
- Read (RWF=1), while synchronized EN is high:
  - O_LCD_DATA_OE=1.
  - RS=0: O_LCD_DATA = {O_BUSY, AC}. Allowed in any state.
  - RS=1: O_LCD_DATA = DDRAM[AC], or 0x20 if AC is outside the window.
  - On the EN fall of an RS=1 read, AC steps. This happens only in IDLE; a data read while busy raises O_ERR.
- States:
  - IDLE → EXEC on an accepted write.
  - EXEC, 1 cycle: apply the command or data. Then:
    - clear → CLEAR;
    - return home → BUSY with count CLR_CYC;
    - 0x00 → IDLE;
    - anything else → BUSY with count BUSY_CYC.
  - CLEAR: writes 0x20 to one of the 32 visible cells per cycle, index 0..31. → BUSY with count CLR_CYC.
  - BUSY: counts down; at 0 → IDLE.
- Reset mid-operation: all state returns to reset values immediately, including an aborted clear walk and the busy count.

## Timing
- Reset values:
  - O_LINE0 and O_LINE1: all 0x20.
  - O_LCD_DATA = 0, O_LCD_DATA_OE = 0.
  - D/C/B = 0, O_FSET_OK = 0, O_BUSY = 0.
  - All strobes 0; AC = 0; ID = 1; state IDLE.
- Edge detect occurs 3 cycles after the raw EN fall (2 synchronizer flops plus 1 edge flop).
- Results appear 1 cycle after EXEC:
  - DDRAM, AC and flag updates are registered and visible then;
  - O_CMD_STB / O_WR_STB pulse in that same cycle.
- O_BUSY rises in the EXEC cycle and falls the cycle the state returns to IDLE.
- Total busy time:
  - normal write: 1 + BUSY_CYC cycles;
  - clear: 1 + 32 + CLR_CYC cycles.
- Write accepted in the cycle busy ends: accepted only if the registered state is IDLE in the edge-detect cycle; otherwise it produces O_ERR.
- OE and read data are registered. They become valid 3 cycles after the raw EN rise and drop 3 cycles after the raw EN fall.

## Structure
- Package lcd_pkg holds:
  - state enum {IDLE, EXEC, CLEAR, BUSY};
  - command bit positions;
  - LINE0_BASE = 7'h00, LINE1_BASE = 7'h40, LINE_LEN = 16;
  - AC wrap points 0x27 and 0x67;
  - BLANK = 8'h20.
- Sub-module lcd_in_sync: 2-flop synchronizer for {EN, RS, RWF, DATA} with reset values, plus EN rise/fall pulse outputs.

## Test plan
- Init sequence 0x38×4, 0x0F, 0x01, 0x06 at the initiator's ~82 µs cadence → no O_ERR; O_FSET_OK=1; D/C/B=1/1/1; all lines 0x20; AC=0.
- 0x80, then "HELLO WORLD 0123", then 0xC0, then "abcdefghijklmnop" → O_LINE0 and O_LINE1 hold those 16 bytes exactly; 34 O_*_STB pulses total.
- Second data write issued 10 cycles after the first → O_ERR pulse; DDRAM unchanged by the second byte; status read returns bit7=1.
- AC=0x27, data write 0x41 → byte discarded, AC reads back 0x40. Entry mode 0x04 with AC=0x00, data write → AC reads back 0x67.
- 0x01 during BUSY_CYC=1000 → O_BUSY high for exactly 1+32+1000 cycles after EXEC; lines blank.
- Assert I_RSTF mid-CLEAR walk → all outputs at reset values next cycle; no edge seen on release with EN held high.
